door_plant_model: RTL and testbench
===================================

# door_plant_model

- Behavioural model of the door mechanism: the plant on the far side of the door controller's motor/sensor interface.
- Consumes the controller's motor commands `Up_M` / `Dn_M`, integrates door position with a step counter, and drives the limit sensors `Up_Max` / `Dn_Max` back to the controller.
- Used in closed-loop benches and FPGA demo builds in place of the real motor and sensors.

## Interface
Parameters:
- `TRAVEL_STEPS`, default 16: position steps from fully closed (0) to fully open; ≥ 1.
- `STEP_DIV`, default 4: clock cycles per position step; ≥ 1.
- `POS_W`, default 5: position width; must satisfy 2^POS_W > TRAVEL_STEPS.

Ports:
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: asynchronous, active-low reset.
- `Up_M` in 1: motor-up command from the controller.
- `Dn_M` in 1: motor-down command from the controller.
- `Up_Max` out 1: door fully open (position == TRAVEL_STEPS).
- `Dn_Max` out 1: door fully closed (position == 0).
- `Position` out POS_W: current door position.
- `Moving` out 1: the position counter is advancing this cycle.
- `Fault` out 1: sticky conflicting-command flag. Driven 0 when `DOOR_PLANT_FAULT_EN` is undefined.

## Operation
- The command is decoded each cycle as one of: STOP (00), UP (Up_M=1, Dn_M=0), DN (Up_M=0, Dn_M=1), BOTH (11).
- FSM states: IDLE, MOVE_UP, MOVE_DN, FAULT (the last only with the macro).
  - The state register holds the command sampled at the last edge.
  - STOP → IDLE. UP → MOVE_UP. DN → MOVE_DN.
  - BOTH without the macro → IDLE.
  - BOTH with the macro → FAULT.
  - FAULT is absorbing until `RST`.
- Divider `div_cnt` (range 0..STEP_DIV-1):
  - Cleared on any edge where the new state differs from the current state, and in IDLE/FAULT.
  - Otherwise incremented on each edge.
  - When it is at STEP_DIV-1, it wraps to 0 and the position steps.
- Stepping:
  - MOVE_UP: +1, saturating at TRAVEL_STEPS.
  - MOVE_DN: −1, saturating at 0.
- Driving into a limit:
  - The position holds and `div_cnt` holds at 0.
  - `Moving` = 0, and no wrap-around occurs.
- `Moving` = 1 in MOVE_UP with Position < TRAVEL_STEPS, or in MOVE_DN with Position > 0.
- `Up_Max` / `Dn_Max` are decoded combinationally from the registered position, so they are glitch-free relative to `CLK`.
- Reversal mid-travel (UP → DN directly): `div_cnt` clears and the position is retained. No extra dead time.

## Timing
- Reset values: Position = 0, state = IDLE, div_cnt = 0, Up_Max = 0, Dn_Max = 1, Moving = 0, Fault = 0.
- Reset mid-motion: the position snaps to 0 immediately (asynchronous), i.e. the door reads as closed. This is intentional so that controller reset tests start from a known state.
- Let E be the first edge sampling UP:
  - The state becomes MOVE_UP at E.
  - The first position increment occurs at edge E+STEP_DIV, then every STEP_DIV edges.
  - `Up_Max` rises after edge E+TRAVEL_STEPS·STEP_DIV. The DN direction is symmetric.
- Command latency: 1 edge from a command change to the state/`Moving` update. The position lags by STEP_DIV edges.
- Simultaneous limit reach and command drop at the same edge: the step completes and the state goes to IDLE.

## Configuration
- `DOOR_PLANT_FAULT_EN` defined:
  - A BOTH command latches FAULT, and `Fault` = 1 from the next edge.
  - Position is frozen and `Moving` = 0 until `RST`.
  - Limit outputs continue to reflect the frozen position.
- Undefined: BOTH is treated as STOP, no FAULT state is generated, and `Fault` is tied 0.

## Structure
- Shared package `door_pkg`:
  - State encoding localparams (IDLE = 2'b00, MOVE_UP = 2'b01, MOVE_DN = 2'b10, FAULT = 2'b11).
  - Command encoding (STOP/UP/DN/BOTH).
  - These are shared with the door controller and benches.
- One sub-module: `door_step_prescaler`.
  - Contains the `div_cnt` counter.
  - Inputs: clear, enable. Output: one-cycle `step` pulse. Parameter: STEP_DIV.
- The FSM, position counter and limit decode stay in the top module.

## Test plan
- Reset check: assert `RST` = 0, release, hold STOP → Position = 0, Dn_Max = 1, Up_Max = 0, Moving = 0, Fault = 0.
- Full open (TRAVEL_STEPS = 16, STEP_DIV = 4): UP from edge 0 → Position = 1 after edge 4 and 8 after edge 32. Up_Max = 1 after edge 64, then Position holds at 16 and Moving = 0.
- Reversal: UP for 20 edges (Position = 5), then DN → Position = 4 after 4 more edges, 0 after 20 more, then Dn_Max = 1.
- Conflict:
  - Without the macro: 11 at Position = 3 → Position holds at 3, Fault = 0.
  - With the macro: Fault = 1 next edge. A subsequent UP for 40 edges leaves Position = 3. `RST` clears Fault and sets Position = 0.
- Reset mid-travel: Position = 9 while moving UP, pulse `RST` low between edges → Position = 0 and Dn_Max = 1 immediately, state = IDLE.
- Closed loop with the door controller: pulse Activate while closed → Up_M asserts, Up_Max reached after 64 edges, Up_M drops. A second Activate closes the door back to Dn_Max = 1.

Source files
------------

// File: rtl/door_pkg.sv
// rtl/door_pkg.sv - shared door state and command encodings
// Purpose: state and motor-command encodings shared by the door controller,
// the door plant model and their benches.
// Optional feature macro: none here (DOOR_PLANT_FAULT_EN is used by door_plant_model).
package door_pkg;

  // Door plant FSM states
  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_MOVE_UP = 2'b01,
    S_MOVE_DN = 2'b10,
    S_FAULT   = 2'b11
  } door_state_e;

  // Motor command as {Up_M, Dn_M}
  typedef enum logic [1:0] {
    CMD_STOP = 2'b00,
    CMD_DN   = 2'b01,
    CMD_UP   = 2'b10,
    CMD_BOTH = 2'b11
  } door_cmd_e;

  function automatic door_cmd_e decode_cmd(input logic up_m, input logic dn_m);
    return door_cmd_e'({up_m, dn_m});
  endfunction

endpackage

// File: rtl/door_step_prescaler.sv
// rtl/door_step_prescaler.sv - clock divider producing position step pulses
// Purpose: counts clock cycles while enabled and flags every STEP_DIV-th one.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : force the divider back to 0 on the next edge
//   enable     : count this cycle
//   step       : one-cycle pulse, high in the cycle whose edge completes a step
module door_step_prescaler #(
  parameter int STEP_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q;
  logic [CNT_W-1:0] div_cnt_d;

  always_comb begin
    // The step fires from the current count even when a clear is also
    // requested, so a step that coincides with a command change completes.
    step      = enable && (div_cnt_q == CNT_MAX);
    div_cnt_d = div_cnt_q;
    if (clear || step) begin
      div_cnt_d = '0;
    end else if (enable) begin
      div_cnt_d = div_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/door_plant_model.sv
// rtl/door_plant_model.sv - behavioural door mechanism (motor + limit sensors)
// Purpose: integrates door position from motor commands and reports limits.
// Optional feature macro: DOOR_PLANT_FAULT_EN (sticky fault on Up_M & Dn_M).
// Ports:
//   CLK, RST       : clock, asynchronous active-low reset
//   Up_M, Dn_M     : motor commands from the door controller
//   Up_Max, Dn_Max : fully open / fully closed limit sensors
//   Position       : current door position (0 = closed)
//   Moving         : position counter advancing this cycle
//   Fault          : sticky conflicting-command flag
module door_plant_model
  import door_pkg::*;
#(
  parameter int TRAVEL_STEPS = 16,
  parameter int STEP_DIV     = 4,
  parameter int POS_W        = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Up_M,
  input  logic             Dn_M,
  output logic             Up_Max,
  output logic             Dn_Max,
  output logic [POS_W-1:0] Position,
  output logic             Moving,
  output logic             Fault
);

  localparam logic [POS_W-1:0] POS_TOP = POS_W'(TRAVEL_STEPS);

  door_state_e      state_q, state_d;
  logic [POS_W-1:0] pos_q, pos_d;
  door_cmd_e        cmd;
  logic             at_top, at_bot;
  logic             moving;
  logic             pre_clear;
  logic             step;

  always_comb begin
    cmd     = decode_cmd(Up_M, Dn_M);
    state_d = S_IDLE;
    case (cmd)
      CMD_STOP: state_d = S_IDLE;
      CMD_UP:   state_d = S_MOVE_UP;
      CMD_DN:   state_d = S_MOVE_DN;
`ifdef DOOR_PLANT_FAULT_EN
      CMD_BOTH: state_d = S_FAULT;
`else
      CMD_BOTH: state_d = S_IDLE;
`endif
      default:  state_d = S_IDLE;
    endcase
`ifdef DOOR_PLANT_FAULT_EN
    if (state_q == S_FAULT) begin
      state_d = S_FAULT;
    end
`endif
  end

  always_comb begin
    at_top = (pos_q == POS_TOP);
    at_bot = (pos_q == '0);
    // Driving into a limit is not motion: divider stays parked at 0.
    moving = ((state_q == S_MOVE_UP) && !at_top) ||
             ((state_q == S_MOVE_DN) && !at_bot);
    pre_clear = (state_d != state_q) || !moving;

    pos_d = pos_q;
    if (step) begin
      if (state_q == S_MOVE_UP) begin
        pos_d = pos_q + POS_W'(1);
      end else begin
        pos_d = pos_q - POS_W'(1);
      end
    end
  end

  door_step_prescaler #(
    .STEP_DIV (STEP_DIV)
  ) u_prescaler (
    .clk    (CLK),
    .rst_n  (RST),
    .clear  (pre_clear),
    .enable (moving),
    .step   (step)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
    end
  end

  assign Position = pos_q;
  assign Up_Max   = at_top;
  assign Dn_Max   = at_bot;
  assign Moving   = moving;
`ifdef DOOR_PLANT_FAULT_EN
  assign Fault    = (state_q == S_FAULT);
`else
  assign Fault    = 1'b0;
`endif

endmodule

// File: tb/tb_door_plant_model.sv
// tb/tb_door_plant_model.sv - scoreboard bench for door_plant_model
module tb_door_plant_model;

  localparam int T  = 16;
  localparam int SD = 4;
  localparam int PW = 5;
`ifdef DOOR_PLANT_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic          CLK;
  logic          RST;
  logic          Up_M;
  logic          Dn_M;
  logic          Up_Max;
  logic          Dn_Max;
  logic [PW-1:0] Position;
  logic          Moving;
  logic          Fault;

  door_plant_model #(
    .TRAVEL_STEPS (T),
    .STEP_DIV     (SD),
    .POS_W        (PW)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Up_M     (Up_M),
    .Dn_M     (Dn_M),
    .Up_Max   (Up_Max),
    .Dn_Max   (Dn_Max),
    .Position (Position),
    .Moving   (Moving),
    .Fault    (Fault)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int pos;
    bit up_max;
    bit dn_max;
    bit moving;
    bit fault;
  } exp_t;

  exp_t sb_q[$];

  // Reference door: direction 0=stopped 1=up 2=down 3=faulted, and a
  // count of cycles spent travelling toward the next step.
  int m_pos    = 0;
  int m_dir    = 0;
  int m_credit = 0;

  function automatic bit model_moving(input int dir, input int pos);
    return (dir == 1 && pos < T) || (dir == 2 && pos > 0);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Apply a command for one edge, predict the outcome, return at edge+1.
  task automatic drive(input bit up, input bit dn);
    int   nd;
    bit   mv;
    exp_t e;
    Up_M = up;
    Dn_M = dn;
    mv = model_moving(m_dir, m_pos);
    if (m_dir == 3)          nd = 3;
    else if (up && !dn)      nd = 1;
    else if (dn && !up)      nd = 2;
    else if (up && dn)       nd = FAULT_EN ? 3 : 0;
    else                     nd = 0;
    if (mv) begin
      m_credit++;
      if (m_credit == SD) begin
        m_pos    = m_pos + ((m_dir == 1) ? 1 : -1);
        m_credit = 0;
      end
    end
    if (nd != m_dir || !mv) m_credit = 0;
    m_dir    = nd;
    e.pos    = m_pos;
    e.up_max = (m_pos == T);
    e.dn_max = (m_pos == 0);
    e.moving = model_moving(m_dir, m_pos);
    e.fault  = (m_dir == 3);
    sb_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_n(input bit up, input bit dn, input int n);
    for (int i = 0; i < n; i++) drive(up, dn);
  endtask

  // Asynchronous reset pulse between edges; the door must read closed at once.
  task automatic pulse_reset();
    #2;
    RST = 1'b0;
    #1;
    check("rst_pos",    32'(Position), 32'd0);
    check("rst_dn_max", 32'(Dn_Max),   32'd1);
    check("rst_up_max", 32'(Up_Max),   32'd0);
    check("rst_moving", 32'(Moving),   32'd0);
    check("rst_fault",  32'(Fault),    32'd0);
    RST      = 1'b1;
    m_pos    = 0;
    m_dir    = 0;
    m_credit = 0;
  endtask

  // Monitor: compare every edge's outputs against the queued prediction.
  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        tests++;
        if (Position !== PW'(e.pos) || Up_Max !== e.up_max || Dn_Max !== e.dn_max ||
            Moving !== e.moving || Fault !== e.fault) begin
          fails++;
          $display("FAIL scoreboard @%0t: got pos=%0d up=%0b dn=%0b mv=%0b f=%0b expected pos=%0d up=%0b dn=%0b mv=%0b f=%0b",
                   $time, Position, Up_Max, Dn_Max, Moving, Fault,
                   e.pos, e.up_max, e.dn_max, e.moving, e.fault);
        end
      end
    end
  end

  initial begin
    RST  = 1'b0;
    Up_M = 1'b0;
    Dn_M = 1'b0;
    #2;
    check("reset_pos",    32'(Position), 32'd0);
    check("reset_dn_max", 32'(Dn_Max),   32'd1);
    check("reset_up_max", 32'(Up_Max),   32'd0);
    check("reset_moving", 32'(Moving),   32'd0);
    check("reset_fault",  32'(Fault),    32'd0);
    RST = 1'b1;

    // Full open: edge 0 samples UP, first step at edge 4, limit at edge 64.
    drive_n(1, 0, 5);
    check("open_pos1", 32'(Position), 32'd1);
    drive_n(1, 0, 28);
    check("open_pos8", 32'(Position), 32'd8);
    drive_n(1, 0, 32);
    check("open_pos16",   32'(Position), 32'd16);
    check("open_up_max",  32'(Up_Max),   32'd1);
    drive_n(1, 0, 4);
    check("open_hold",    32'(Position), 32'd16);
    check("open_moving0", 32'(Moving),   32'd0);
    pulse_reset();

    // Reset while travelling up at position 9.
    drive_n(1, 0, 37);
    check("mid_pos9",    32'(Position), 32'd9);
    check("mid_moving1", 32'(Moving),   32'd1);
    pulse_reset();

    // Reversal mid-travel.
    drive_n(1, 0, 21);
    check("rev_pos5", 32'(Position), 32'd5);
    drive_n(0, 1, 5);
    check("rev_pos4", 32'(Position), 32'd4);
    drive_n(0, 1, 20);
    check("rev_pos0",   32'(Position), 32'd0);
    check("rev_dn_max", 32'(Dn_Max),   32'd1);

    // Conflicting command at position 3.
    drive_n(1, 0, 13);
    check("conf_pos3", 32'(Position), 32'd3);
    drive_n(1, 1, 10);
    check("conf_hold",   32'(Position), 32'd3);
    check("conf_moving", 32'(Moving),   32'd0);
`ifdef DOOR_PLANT_FAULT_EN
    check("conf_fault", 32'(Fault), 32'd1);
    drive_n(1, 0, 40);
    check("fault_frozen", 32'(Position), 32'd3);
    pulse_reset();
`else
    check("conf_fault", 32'(Fault), 32'd0);
`endif

    // Randomized command runs with occasional reset pulses.
    for (int s = 0; s < 40; s++) begin
      int r;
      int len;
      r   = $urandom_range(0, 9);
      len = $urandom_range(1, 40);
      if (r <= 3)      drive_n(1, 0, len);
      else if (r <= 7) drive_n(0, 1, len);
      else if (r == 8) drive_n(0, 0, len);
      else             drive_n(1, 1, len);
      if ($urandom_range(0, 9) == 0) pulse_reset();
    end

    drive(0, 0);
    #5;
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
